// File: rtl/xor_pg_pkg.sv
// Shared types and constants for the XOR share feeder.
// Holds the Galois LFSR taps and reset state, the feeder FSM encoding,
// the registered share bundle layout and the single-step LFSR function.
package xor_pg_pkg;

  localparam int unsigned LFSR_W       = 32;
  localparam int unsigned STEPS_PER_OP = 5;

  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_UNSEEDED = 2'd0,
    ST_WARMUP   = 2'd1,
    ST_RUN      = 2'd2
  } feeder_state_e;

  // Registered output payload: two shares per operand plus gadget randomness.
  typedef struct packed {
    logic a0;
    logic a1;
    logic b0;
    logic b1;
    logic r0;
    logic r1;
    logic r2;
  } share_bundle_t;

  // One right-shift Galois step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ LFSR_TAPS;
    end
    return n;
  endfunction

endpackage

// File: rtl/xor_pg_share_feeder_if.sv
// Operand-in / share-bundle-out handshake bundle of the XOR share feeder.
// slave  : the feeder side (accepts operands, produces shares).
// master : the environment side (supplies operands, consumes shares).
interface xor_pg_share_feeder_if;

  logic in_valid;
  logic in_ready;
  logic in_a;
  logic in_b;
  logic out_valid;
  logic out_ready;
  logic a0;
  logic a1;
  logic b0;
  logic b1;
  logic r0;
  logic r1;
  logic r2;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, a0, a1, b0, b1, r0, r1, r2
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, a0, a1, b0, b1, r0, r1, r2
  );

endinterface

// File: rtl/xor_pg_lfsr32.sv
// 32-bit Galois LFSR with load, single-step and five-step advance.
// Ports: clk, rst_n (async, active-low), load (seed, zero maps to 1),
//        step1 (advance one step), step5 (advance five steps),
//        seed (load value), state (current LFSR state).
// Priority: load > step5 > step1; otherwise the state holds.
module xor_pg_lfsr32
  import xor_pg_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step1,
  input  logic              step5,
  input  logic [LFSR_W-1:0] seed,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;
  logic [LFSR_W-1:0] step5_c;

  // Unrolled five-step advance used once per accepted operand pair.
  always_comb begin
    step5_c = state_q;
    for (int unsigned i = 0; i < STEPS_PER_OP; i++) begin
      step5_c = lfsr_step(step5_c);
    end
  end

  // Next state; an all-zero seed would lock the register, so it loads 1.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == '0) ? LFSR_DEFAULT : seed;
    end else if (step5) begin
      state_d = step5_c;
    end else if (step1) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LFSR_DEFAULT;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/xor_pg_share_feeder.sv
// Splits unmasked operand bits into Boolean shares for a masked XOR gate
// and supplies fresh randomness alongside each bundle.
// Ports: clk, rst_n (async, active-low), seed_load/seed (reseed PRNG),
//        bus (slave side of the operand/share handshake),
//        ops_cnt (accepted pair count, wraps modulo 2^CNT_W).
// After a seed load the PRNG is warmed up for WARMUP steps before operands
// are accepted; each accept consumes five fresh LFSR bits.
module xor_pg_share_feeder
  import xor_pg_pkg::*;
#(
  parameter int unsigned WARMUP = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed,
  xor_pg_share_feeder_if.slave  bus,
  output logic [CNT_W-1:0]      ops_cnt
);

  localparam int unsigned WC_W = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);

  feeder_state_e     state_q;
  feeder_state_e     state_d;
  logic [WC_W-1:0]   wcnt_q;
  logic [WC_W-1:0]   wcnt_d;
  logic [CNT_W-1:0]  ops_cnt_q;
  logic [CNT_W-1:0]  ops_cnt_d;
  logic              out_valid_q;
  logic              out_valid_d;
  share_bundle_t     bundle_q;
  share_bundle_t     bundle_d;

  logic              in_ready_c;
  logic              accept_c;
  logic              lfsr_step1_c;
  logic [LFSR_W-1:0] lfsr_state;
  logic              lfsr_unused;

  xor_pg_lfsr32 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (seed_load),
    .step1 (lfsr_step1_c),
    .step5 (accept_c),
    .seed  (seed),
    .state (lfsr_state)
  );

  // Upper LFSR bits only feed the register's own next state.
  assign lfsr_unused = ^lfsr_state[LFSR_W-1:STEPS_PER_OP];

  // Next-state, handshake and share generation; seed_load overrides all.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    ops_cnt_d    = ops_cnt_q;
    out_valid_d  = out_valid_q;
    bundle_d     = bundle_q;
    in_ready_c   = 1'b0;
    accept_c     = 1'b0;
    lfsr_step1_c = 1'b0;

    if (seed_load) begin
      state_d     = ST_WARMUP;
      wcnt_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_UNSEEDED: begin
          state_d = ST_UNSEEDED;
        end

        // WARMUP discarded steps, then one cycle to hand over to RUN.
        ST_WARMUP: begin
          if (wcnt_q < WC_W'(WARMUP)) begin
            lfsr_step1_c = 1'b1;
            wcnt_d       = wcnt_q + WC_W'(1);
          end else begin
            state_d = ST_RUN;
          end
        end

        // Single-entry output stage: refill when empty or being drained.
        ST_RUN: begin
          in_ready_c = !out_valid_q || bus.out_ready;
          accept_c   = bus.in_valid && in_ready_c;
          if (accept_c) begin
            out_valid_d = 1'b1;
            ops_cnt_d   = ops_cnt_q + CNT_W'(1);
            // Operands are mixed with the mask before reaching a register.
            bundle_d.a0 = bus.in_a ^ lfsr_state[0];
            bundle_d.a1 = lfsr_state[0];
            bundle_d.b0 = bus.in_b ^ lfsr_state[1];
            bundle_d.b1 = lfsr_state[1];
            bundle_d.r0 = lfsr_state[2];
            bundle_d.r1 = lfsr_state[3];
            bundle_d.r2 = lfsr_state[4];
          end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
          end
        end

        default: begin
          state_d = ST_UNSEEDED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_UNSEEDED;
      wcnt_q      <= '0;
      ops_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      ops_cnt_q   <= ops_cnt_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.a0        = bundle_q.a0;
  assign bus.a1        = bundle_q.a1;
  assign bus.b0        = bundle_q.b0;
  assign bus.b1        = bundle_q.b1;
  assign bus.r0        = bundle_q.r0;
  assign bus.r1        = bundle_q.r1;
  assign bus.r2        = bundle_q.r2;
  assign ops_cnt       = ops_cnt_q;

endmodule

// File: tb/tb_xor_pg_share_feeder.sv
// Directed, table-driven bench for xor_pg_share_feeder with a Galois
// reference model for the mask and randomness bits.
module tb_xor_pg_share_feeder;
  import xor_pg_pkg::*;

  localparam int unsigned WARMUP = 32;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              seed_load;
  logic [31:0]       seed;
  logic [CNT_W-1:0]  ops_cnt;

  xor_pg_share_feeder_if bus_if ();

  xor_pg_share_feeder #(
    .WARMUP (WARMUP),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .bus       (bus_if),
    .ops_cnt   (ops_cnt)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [31:0]      m_s;
  logic [CNT_W-1:0] exp_ops;
  logic [6:0]       last_exp;
  logic [6:0]       got_bundle;

  assign got_bundle = {bus_if.a0, bus_if.a1, bus_if.b0, bus_if.b1,
                       bus_if.r0, bus_if.r1, bus_if.r2};

  typedef struct {
    logic in_a;
    logic in_b;
    logic exp_ax;
    logic exp_bx;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [6:0] exp_bundle(input logic a, input logic b, input logic [31:0] s);
    return {a ^ s[0], s[0], b ^ s[1], s[1], s[2], s[3], s[4]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reseed, confirm the warm-up length, and align the reference model.
  task automatic seed_and_warm(input logic [31:0] sd, input string name);
    int cyc;
    seed      = sd;
    seed_load = 1'b1;
    #1;
    check({name, "_rdy_in_load"}, 32'(bus_if.in_ready), 32'd0);
    tick();
    seed_load = 1'b0;
    check({name, "_ovalid_cleared"}, 32'(bus_if.out_valid), 32'd0);
    check({name, "_ops_kept"}, 32'(ops_cnt), 32'(exp_ops));
    cyc = 0;
    while (!bus_if.in_ready && cyc < 200) begin
      tick();
      cyc++;
    end
    check({name, "_warm_cycles"}, 32'(cyc), 32'(WARMUP + 1));
    m_s = (sd == 32'd0) ? 32'd1 : sd;
    for (int i = 0; i < int'(WARMUP); i++) m_s = ref_step(m_s);
  endtask

  // Present one pair, expect it accepted, check the registered bundle.
  task automatic accept_one(input logic a, input logic b, input logic ax, input logic bx,
                            input string name);
    bus_if.in_valid  = 1'b1;
    bus_if.in_a      = a;
    bus_if.in_b      = b;
    bus_if.out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
    last_exp = exp_bundle(a, b, m_s);
    tick();
    for (int i = 0; i < 5; i++) m_s = ref_step(m_s);
    exp_ops = exp_ops + CNT_W'(1);
    check({name, "_out_valid"}, 32'(bus_if.out_valid), 32'd1);
    check({name, "_bundle"}, 32'(got_bundle), 32'(last_exp));
    check({name, "_a_xor"}, 32'(bus_if.a0 ^ bus_if.a1), 32'(ax));
    check({name, "_b_xor"}, 32'(bus_if.b0 ^ bus_if.b1), 32'(bx));
    check({name, "_ops_cnt"}, 32'(ops_cnt), 32'(exp_ops));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n            = 1'b1;
    seed_load        = 1'b0;
    seed             = 32'd0;
    bus_if.in_valid  = 1'b0;
    bus_if.in_a      = 1'b0;
    bus_if.in_b      = 1'b0;
    bus_if.out_ready = 1'b0;
    exp_ops          = '0;
    m_s              = 32'd1;
    last_exp         = '0;

    // in_a, in_b, expected a0^a1, expected b0^b1
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1};

    #1 rst_n = 1'b0;
    #11;
    check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("rst_ops_cnt", 32'(ops_cnt), 32'd0);
    check("rst_bundle", 32'(got_bundle), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unseeded: offered operands are never taken.
    bus_if.in_valid = 1'b1;
    bus_if.in_a     = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("unseeded_in_ready", 32'(bus_if.in_ready), 32'd0);
    end
    check("unseeded_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("unseeded_ops_cnt", 32'(ops_cnt), 32'd0);
    bus_if.in_valid = 1'b0;

    // Zero seed is replaced by 1.
    seed_and_warm(32'd0, "seed0");
    accept_one(1'b1, 1'b0, 1'b1, 1'b0, "seed0_acc");
    bus_if.in_valid = 1'b0;
    tick();
    check("drain_out_valid", 32'(bus_if.out_valid), 32'd0);

    // Table: all operand pairs, back to back.
    seed_and_warm(32'hACE1_0001, "seedace");
    for (int i = 0; i < 8; i++) begin
      accept_one(tbl[i].in_a, tbl[i].in_b, tbl[i].exp_ax, tbl[i].exp_bx, $sformatf("tbl%0d", i));
    end

    // Backpressure: bundle frozen, nothing accepted.
    bus_if.out_ready = 1'b0;
    bus_if.in_a      = ~bus_if.in_a;
    bus_if.in_b      = ~bus_if.in_b;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
      tick();
      check("stall_out_valid", 32'(bus_if.out_valid), 32'd1);
      check("stall_bundle", 32'(got_bundle), 32'(last_exp));
      check("stall_ops_cnt", 32'(ops_cnt), 32'(exp_ops));
    end

    // Release: consume and refill on the same edge, one pair per cycle.
    for (int i = 0; i < 4; i++) begin
      accept_one(tbl[3 - i].in_a, tbl[3 - i].in_b, tbl[3 - i].exp_ax, tbl[3 - i].exp_bx,
                 $sformatf("b2b%0d", i));
    end
    bus_if.in_valid = 1'b0;
    tick();
    check("consume_clears_valid", 32'(bus_if.out_valid), 32'd0);

    // Reseed with a full bundle and a pending operand: no accept.
    accept_one(1'b0, 1'b1, 1'b0, 1'b1, "pre_reseed");
    seed_and_warm(32'h1234_5678, "reseed_busy");
    accept_one(1'b1, 1'b1, 1'b1, 1'b1, "post_reseed");

    // Reset with a bundle in flight discards it.
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    rst_n            = 1'b0;
    #1;
    exp_ops = '0;
    check("midrst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check("midrst_bundle", 32'(got_bundle), 32'd0);
    check("midrst_ops_cnt", 32'(ops_cnt), 32'd0);
    check("midrst_in_ready", 32'(bus_if.in_ready), 32'd0);
    tick();
    rst_n           = 1'b1;
    bus_if.in_valid = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    bus_if.in_valid = 1'b0;

    // Counter wrap.
    seed_and_warm(32'h0BAD_F00D, "wrapseed");
    bus_if.in_valid  = 1'b1;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    exp_ops = 16'hFFFF;
    check("ops_cnt_ffff", 32'(ops_cnt), 32'(exp_ops));
    bus_if.in_valid = 1'b1;
    tick();
    bus_if.in_valid = 1'b0;
    exp_ops = exp_ops + CNT_W'(1);
    check("ops_cnt_wrap", 32'(ops_cnt), 32'(exp_ops));
    check("ops_cnt_wrap_zero", 32'(ops_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_pg_share_feeder.md
XOR_PG_SHARE_FEEDER -- requirements
Module: xor_pg_share_feeder

Interface
REQ-001 SHALL expose the parameter WARMUP, default 32, the number of LFSR steps discarded after each seed load.
REQ-002 SHALL expose the parameter CNT_W, default 16, the width of the operation counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 seed_load  input  1  pulse that loads seed into the PRNG.
REQ-006 seed  input  32  PRNG seed value.
REQ-007 in_valid  input  1  unmasked operand pair present.
REQ-008 in_ready  output  1  operand pair accepted this cycle when in_valid is also high.
REQ-009 in_a, in_b  input  1 each  unmasked operand bits.
REQ-010 out_valid  output  1  share bundle valid.
REQ-011 out_ready  input  1  downstream masked XOR gate consumes the bundle.
REQ-012 a0, a1, b0, b1  output  1 each  Boolean shares of in_a and in_b.
REQ-013 r0, r1, r2  output  1 each  fresh gadget randomness for the downstream masked XOR gate.
REQ-014 ops_cnt  output  CNT_W  count of accepted operand pairs; wraps modulo 2^CNT_W.

Function
REQ-015 The FSM SHALL have the states UNSEEDED, WARMUP and RUN.
REQ-016 UNSEEDED SHALL hold in_ready=0 and leave the LFSR idle; seed_load moves the FSM to WARMUP.
REQ-017 WARMUP SHALL step the LFSR once per cycle for WARMUP cycles, hold in_ready=0, then enter RUN.
REQ-018 On seed_load in any state, the block SHALL load the LFSR with seed, or with 32'h1 if seed==0, clear the warm-up counter, clear out_valid on the next edge and enter WARMUP.
REQ-019 seed_load SHALL take priority over every other event; in_ready SHALL be 0 combinationally whenever seed_load=1.
REQ-020 In RUN, in_ready SHALL equal (!out_valid || out_ready), giving single-entry pipeline semantics at a throughput of one pair per cycle.
REQ-021 The LFSR SHALL be 32-bit right-shift Galois: lsb=S[0]; S=S>>1; if lsb then S^=32'h80200003; S SHALL never become zero.
REQ-022 On accept (in_valid && in_ready), with S the current LFSR state, the randomness bits SHALL be m_a=S[0], m_b=S[1], r0=S[2], r1=S[3], r2=S[4].
REQ-023 On accept, the outputs SHALL register a0=in_a^m_a, a1=m_a, b0=in_b^m_b, b1=m_b, and r0..r2 as in REQ-022, with out_valid=1 at the next edge (latency 1).
REQ-024 On accept, the LFSR SHALL advance exactly 5 steps in the same edge; with no accept in RUN, the LFSR SHALL hold.
REQ-025 While out_valid && !out_ready, all share and randomness outputs SHALL stay stable.
REQ-026 When out_ready=1 and there is no new accept, out_valid SHALL clear at the next edge.
REQ-027 Simultaneous consume and accept SHALL replace the bundle with out_valid remaining 1.
REQ-028 ops_cnt SHALL increment on each accept and wrap from all-ones to 0; seed_load SHALL NOT clear it.
REQ-029 Unmasked in_a/in_b SHALL never be driven onto any output and never stored in a register unmixed.

Reset
REQ-030 rst_n low SHALL asynchronously set state=UNSEEDED, LFSR=32'h1, warm-up counter=0, ops_cnt=0, out_valid=0, and a0, a1, b0, b1, r0, r1, r2 all 0; in_ready SHALL be 0 during reset.
REQ-031 Reset deassertion SHALL take effect at the first rising clk edge after release; reset in the middle of a transfer SHALL discard the bundle.

Structure
REQ-032 Package xor_pg_pkg SHALL hold LFSR_TAPS=32'h80200003, the default LFSR state 32'h1, the FSM state enum, and a single-step LFSR function.
REQ-033 The 5-step LFSR advance SHALL be one sub-module, xor_pg_lfsr32, with ports for load, step1, step5, seed and state; all other logic SHALL be in the top module.

Verification
REQ-034 Reset, then in_valid=1 with no seed_load for 50 cycles -> in_ready=0, out_valid=0, ops_cnt=0.
REQ-035 seed_load with seed=0 -> LFSR state is 32'h1; in_ready rises exactly WARMUP+1 cycles after the seed_load edge.
REQ-036 Seed 32'hACE1_0001, then all four (in_a,in_b) pairs -> a0^a1==in_a, b0^b1==in_b, and m_a, m_b, r0..r2 match a bit-exact Galois reference model.
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> outputs constant and in_ready=0; releasing out_ready while in_valid=1 -> back-to-back transfers, one per cycle.
REQ-038 seed_load asserted with out_valid=1 and in_valid=1 -> no accept, out_valid=0 the next cycle, FSM in WARMUP.
REQ-039 Preload 0xFFFF accepts -> ops_cnt==16'hFFFF; one more accept -> ops_cnt==0.
